// File: rtl/hpu_lm_xbar_pkg.sv
// Shared helpers for the banked local-memory crossbar.
// Contents:
//   lm_idx_w - index width for n items, never below 1 bit
//   lm_aw    - word-address width spanning nbank * depth words
package hpu_lm_xbar_pkg;

    // Single-entry fields still get one bit so declarations stay legal.
    function automatic int unsigned lm_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned lm_aw(input int unsigned nbank, input int unsigned depth);
        return lm_idx_w(nbank) + lm_idx_w(depth);
    endfunction

endpackage

// File: rtl/hpu_lm_xbar_rr_arb.sv
// Round-robin arbiter with a high-priority class, purely combinational.
// Ports:
//   req_i   - request vector
//   hipri_i - high-priority mask; if any masked port requests, only those compete
//   ptr_i   - first index to consider (circular search start)
//   gnt_o   - one-hot grant
//   idx_o   - index of the granted requestor
//   valid_o - a grant was issued
module hpu_lm_xbar_rr_arb
    import hpu_lm_xbar_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PW = lm_idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  hipri_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    logic [N-1:0] elig;
    logic [PW:0]  sum;
    logic [PW-1:0] k;

    always_comb begin
        elig    = ((req_i & hipri_i) != '0) ? (req_i & hipri_i) : req_i;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        k       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr_i < N and i < N, so one conditional subtract wraps the index.
            sum = {1'b0, ptr_i} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            k = sum[PW-1:0];
            if (!valid_o && elig[k]) begin
                valid_o  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/hpu_lm_xbar.sv
// Banked local-memory crossbar: NPORT requestors share NBANK single-port banks.
// Each bank has its own round-robin arbiter (with optional high-priority ports).
// Reads return two cycles after grant through a per-port {valid, bank} pipeline.
// Ports:
//   clk_i      - clock
//   rst_i      - asynchronous active-low reset
//   req_i      - per-port request
//   we_i       - per-port write enable (1 = write)
//   addr_i     - per-port word address, AW bits each
//   wdata_i    - per-port write data
//   wstrb_i    - per-port byte strobes
//   gnt_o      - combinational grant
//   rvalid_o   - registered read-data valid
//   rdata_o    - registered read data, held while rvalid_o is low
//   conflict_o - per-port saturating count of denied request cycles
//   cnt_clr_i  - synchronous clear of all conflict counters
module hpu_lm_xbar
    import hpu_lm_xbar_pkg::*;
#(
    parameter int unsigned      NPORT      = 4,
    parameter int unsigned      NBANK      = 8,
    parameter int unsigned      BANK_DEPTH = 512,
    parameter int unsigned      DATA_WTH   = 64,
    parameter bit               INTERLEAVE = 1'b0,
    parameter logic [NPORT-1:0] HIPRI_MASK = '0,
    parameter int unsigned      CNT_WTH    = 16,
    localparam int unsigned     AW         = lm_aw(NBANK, BANK_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NPORT-1:0]            req_i,
    input  logic [NPORT-1:0]            we_i,
    input  logic [NPORT*AW-1:0]         addr_i,
    input  logic [NPORT*DATA_WTH-1:0]   wdata_i,
    input  logic [NPORT*DATA_WTH/8-1:0] wstrb_i,
    output logic [NPORT-1:0]            gnt_o,
    output logic [NPORT-1:0]            rvalid_o,
    output logic [NPORT*DATA_WTH-1:0]   rdata_o,
    output logic [NPORT*CNT_WTH-1:0]    conflict_o,
    input  logic                        cnt_clr_i
);

    localparam int unsigned BW = lm_idx_w(NBANK);
    localparam int unsigned OW = lm_idx_w(BANK_DEPTH);
    localparam int unsigned SW = DATA_WTH / 8;
    localparam int unsigned PW = lm_idx_w(NPORT);

    typedef struct packed {
        logic                we;
        logic [AW-1:0]       addr;
        logic [DATA_WTH-1:0] wdata;
        logic [SW-1:0]       wstrb;
    } lm_xbar_req_t;

    lm_xbar_req_t        port_req  [NPORT];
    logic [BW-1:0]       port_bank [NPORT];
    logic [OW-1:0]       port_off  [NPORT];
    logic [NPORT-1:0]    bank_gnt  [NBANK];
    logic [DATA_WTH-1:0] bank_rd   [NBANK];

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            port_req[p].we    = we_i[p];
            port_req[p].addr  = addr_i[p*AW +: AW];
            port_req[p].wdata = wdata_i[p*DATA_WTH +: DATA_WTH];
            port_req[p].wstrb = wstrb_i[p*SW +: SW];
        end
    end

    // Bank select from address MSBs (contiguous) or LSBs (word-interleaved).
    if (INTERLEAVE) begin : g_dec_il
        always_comb begin
            for (int p = 0; p < NPORT; p++) begin
                port_bank[p] = port_req[p].addr[BW-1:0];
                port_off[p]  = port_req[p].addr[AW-1 -: OW];
            end
        end
    end else begin : g_dec_hi
        always_comb begin
            for (int p = 0; p < NPORT; p++) begin
                port_bank[p] = port_req[p].addr[AW-1 -: BW];
                port_off[p]  = port_req[p].addr[OW-1:0];
            end
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [NPORT-1:0]    cand;
        logic [PW-1:0]       ptr_q;
        logic [PW-1:0]       win;
        logic                any;
        logic                sel_we;
        logic [OW-1:0]       sel_off;
        logic [DATA_WTH-1:0] sel_wdata;
        logic [DATA_WTH-1:0] bmask;
        logic [DATA_WTH-1:0] mem [BANK_DEPTH];
        logic [DATA_WTH-1:0] rd_q;

        always_comb begin
            for (int p = 0; p < NPORT; p++) begin
                cand[p] = req_i[p] && (port_bank[p] == BW'(b));
            end
        end

        hpu_lm_xbar_rr_arb #(
            .N (NPORT)
        ) u_arb (
            .req_i   (cand),
            .hipri_i (HIPRI_MASK),
            .ptr_i   (ptr_q),
            .gnt_o   (bank_gnt[b]),
            .idx_o   (win),
            .valid_o (any)
        );

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                ptr_q <= '0;
            end else if (any) begin
                ptr_q <= (win == PW'(NPORT - 1)) ? '0 : win + 1'b1;
            end
        end

        always_comb begin
            sel_we    = port_req[win].we;
            sel_off   = port_off[win];
            sel_wdata = port_req[win].wdata;
            for (int i = 0; i < SW; i++) begin
                bmask[i*8 +: 8] = {8{port_req[win].wstrb[i]}};
            end
        end

        // Single-port SRAM: one access per cycle, registered read data.
        always_ff @(posedge clk_i) begin
            if (any) begin
                if (sel_we) begin
                    mem[sel_off] <= (mem[sel_off] & ~bmask) | (sel_wdata & bmask);
                end else begin
                    rd_q <= mem[sel_off];
                end
            end
        end

        assign bank_rd[b] = rd_q;
    end

    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NBANK; b++) begin
            gnt_o = gnt_o | bank_gnt[b];
        end
    end

    // Return path: stage 1 tracks {valid, bank} alongside the SRAM access,
    // stage 2 is the output register that captures the selected bank data.
    logic [NPORT-1:0]          rd_vld_q;
    logic [BW-1:0]             rd_bank_q [NPORT];
    logic [NPORT-1:0]          rvalid_q;
    logic [NPORT*DATA_WTH-1:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_vld_q <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            for (int p = 0; p < NPORT; p++) begin
                rd_bank_q[p] <= '0;
            end
        end else begin
            rd_vld_q <= gnt_o & ~we_i;
            rvalid_q <= rd_vld_q;
            for (int p = 0; p < NPORT; p++) begin
                rd_bank_q[p] <= port_bank[p];
                if (rd_vld_q[p]) begin
                    rdata_q[p*DATA_WTH +: DATA_WTH] <= bank_rd[rd_bank_q[p]];
                end
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

    logic [CNT_WTH-1:0] cnt_q [NPORT];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int p = 0; p < NPORT; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (cnt_clr_i) begin
                    cnt_q[p] <= '0;
                end else if (req_i[p] && !gnt_o[p] && (cnt_q[p] != '1)) begin
                    cnt_q[p] <= cnt_q[p] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            conflict_o[p*CNT_WTH +: CNT_WTH] = cnt_q[p];
        end
    end

endmodule
